riscv_mtimer: RTL and testbench
===============================

// Module: riscv_mtimer
// PURPOSE
// - Memory-mapped machine timer (mtime/mtimecmp); upstream source of timer_irq for the CSR/trap controller.
// - Sits on the data-memory bus beside RAM; claims the top 16 bytes of the legal load/store window (0xc000-0xc00c).
// - Drives a registered level interrupt that stays high while mtime >= mtimecmp. Software clears it by writing mtimecmp.
// PARAMETERS
// BASE_ADDR   32'h0000c000   byte address of the 16-byte register window; bits [3:0] must be 0
// PRESCALE    1              clk cycles per mtime increment; legal range 1..65535
// PORTS
// clk         in   1   single clock; all state changes on its rising edge
// rst         in   1   asynchronous, active-low reset (asserted at 0)
// count_en    in   1   1 = mtime advances; 0 = mtime and prescaler are frozen (debug halt)
// bus_en      in   1   data-bus access strobe, asserted for one cycle per access
// dmem_op     in   3   bit2 = store, 0 = load; [1:0] = size; only 2'd3 (word) is serviced
// addr        in   32  byte address of the access
// wdata       in   32  store data
// rdata       out  32  load data, registered; valid the cycle after the load strobe
// sel         out  1   registered; 1 = previous-cycle load hit this block (read-mux select)
// timer_irq   out  1   registered level: mtime >= mtimecmp
// BEHAVIOUR
// - Register map (offset = addr[3:2]): 0 = mtime[31:0], 1 = mtime[63:32], 2 = mtimecmp[31:0], 3 = mtimecmp[63:32].
// - Hit condition: bus_en & (addr[31:4] == BASE_ADDR[31:4]) & (addr[1:0] == 0) & (dmem_op[1:0] == 3).
// - A store with no hit has no effect. A load with no hit sets sel=0 and rdata=0 on the next edge.
// - Reset values: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, prescale count = 0, shadow_hi = 0, rdata = 0, sel = 0, timer_irq = 0.
// - Prescaler: counter pc runs 0..PRESCALE-1 while count_en = 1.
//   - A tick occurs when pc == PRESCALE-1; pc then returns to 0.
//   - On a tick, mtime <= mtime + 1 (64-bit; wraps from 64'hFFFF..F to 0 and nothing else happens).
//   - When PRESCALE = 1, every count_en cycle is a tick.
// - Store to mtime lo or hi: replaces that half with wdata and clears pc to 0.
//   - If a store and a tick fall in the same cycle, the store wins; that increment is dropped and the other half is unchanged.
// - Store to mtimecmp lo or hi: replaces that half only. No hardware atomicity; software writes hi = all-ones first.
// - Coherent 64-bit read of mtime:
//   - A load of mtime lo returns the current mtime[31:0] and latches mtime[63:32] into shadow_hi in the same cycle.
//   - A load of mtime hi returns shadow_hi, not the live value.
//   - A store to mtime hi also loads shadow_hi with wdata.
// - Loads of mtimecmp return the live value.
// - Load latency is 1 cycle: rdata and sel update on the edge after the strobe and hold until the next strobe.
//   - A cycle with bus_en = 0 leaves rdata and sel unchanged.
//   - A store clears sel to 0.
// - timer_irq <= (mtime >= mtimecmp), an unsigned 64-bit compare of the pre-edge register values.
//   - timer_irq lags any change of mtime or mtimecmp by exactly 1 cycle.
//   - After a store of mtimecmp that moves the compare above mtime, timer_irq drops on the edge after the store edge.
// - count_en = 0: pc and mtime hold. Bus accesses and the compare continue to work.
// - Reset asserted mid-operation: all state returns to reset values immediately, regardless of the clock.
//   - After release, the first tick comes PRESCALE count_en cycles later.
// - No FSM beyond the prescaler and the shadow latch. There are no bus errors; access faults are raised by the trap controller.
// STRUCTURE
// - Shared package riscv_pkg holds:
//   - MTIMER_OFF_TIME_LO/HI, MTIMER_OFF_CMP_LO/HI (2-bit offsets).
//   - DMEM_OP_STORE_BIT = 2 and DMEM_SIZE_WORD = 2'd3.
//   - MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF.
// - One sub-module, riscv_prescaler (PRESCALE parameter):
//   - Inputs clk, rst, en, clear; output tick.
//   - Counter width is $clog2(PRESCALE+1).
// - Everything else (address decode, register file, shadow latch, compare, read register) lives in riscv_mtimer.
// TESTING
// - Reset then PRESCALE=1, count_en=1 for 10 cycles -> load 0xc000 returns 10 (+1 per cycle of load latency), timer_irq stays 0.
// - Store 0xc00c=0, 0xc008=5; count to 5 -> timer_irq rises exactly 1 cycle after mtime reaches 5; store 0xc008=100 -> falls 1 cycle later.
// - Store mtime=0x0000_0000_FFFF_FFFF, tick, then load lo, load hi -> 0x0000_0000 then 0x0000_0001 (shadow coherent).
// - Store mtime lo=0xFFFF_FFFF, hi=0xFFFF_FFFF, tick -> mtime=0, timer_irq reflects wrap vs mtimecmp.
// - PRESCALE=4: 12 cycles with count_en=0 for 4 of them -> mtime=2; store to mtime in a tick cycle -> written value kept, no increment.
// - Load at 0xc010, halfword load at 0xc000, and rst pulse mid-count -> rdata=0, sel=0, all registers back to reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the memory-mapped machine timer and its bus decode.
package riscv_pkg;

  // Word offsets (addr[3:2]) inside the 16-byte timer window
  localparam logic [1:0] MTIMER_OFF_TIME_LO = 2'd0;
  localparam logic [1:0] MTIMER_OFF_TIME_HI = 2'd1;
  localparam logic [1:0] MTIMER_OFF_CMP_LO  = 2'd2;
  localparam logic [1:0] MTIMER_OFF_CMP_HI  = 2'd3;

  // dmem_op encoding: bit 2 selects store, [1:0] is the access size
  localparam int         DMEM_OP_STORE_BIT = 2;
  localparam logic [1:0] DMEM_SIZE_WORD    = 2'd3;

  // Compare value out of reset: never reached, so no interrupt until programmed
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/riscv_prescaler.sv
// Divides count-enabled clk cycles down to one mtime tick every PRESCALE cycles.
module riscv_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int             W    = $clog2(PRESCALE + 1);
  localparam logic [W-1:0]   LAST = W'(PRESCALE - 1);

  logic [W-1:0] pc;

  assign tick = en & (pc == LAST);

  // Count enabled cycles; a software write to mtime restarts the period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         pc <= '0;
    else if (clear)   pc <= '0;
    else if (en)      pc <= tick ? '0 : pc + 1'b1;
  end

endmodule

// File: rtl/riscv_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp on the data bus with a level timer_irq.
module riscv_mtimer
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_c000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_en,
  input  logic        bus_en,
  input  logic [2:0]  dmem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        timer_irq
);

  logic        hit, is_st, wr, rd, tick;
  logic        wr_time_lo, wr_time_hi, wr_cmp_lo, wr_cmp_hi;
  logic [1:0]  off;
  logic [63:0] mtime, mtimecmp;
  logic [31:0] shadow_hi, rd_val;

  assign hit   = bus_en && (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00) &&
                 (dmem_op[1:0] == DMEM_SIZE_WORD);
  assign is_st = dmem_op[DMEM_OP_STORE_BIT];
  assign wr    = hit & is_st;
  assign rd    = hit & ~is_st;
  assign off   = addr[3:2];

  assign wr_time_lo = wr && (off == MTIMER_OFF_TIME_LO);
  assign wr_time_hi = wr && (off == MTIMER_OFF_TIME_HI);
  assign wr_cmp_lo  = wr && (off == MTIMER_OFF_CMP_LO);
  assign wr_cmp_hi  = wr && (off == MTIMER_OFF_CMP_HI);

  riscv_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (count_en),
    .clear (wr_time_lo | wr_time_hi),
    .tick  (tick)
  );

  // mtime: a software write beats a coincident tick and drops that increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            mtime <= '0;
    else if (wr_time_lo) mtime[31:0]  <= wdata;
    else if (wr_time_hi) mtime[63:32] <= wdata;
    else if (tick)       mtime <= mtime + 64'd1;
  end

  // mtimecmp: independent half writes, no atomicity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           mtimecmp <= MTIMECMP_RESET;
    else if (wr_cmp_lo) mtimecmp[31:0]  <= wdata;
    else if (wr_cmp_hi) mtimecmp[63:32] <= wdata;
  end

  // Shadow of the upper half so a lo-then-hi read pair sees one 64-bit value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    shadow_hi <= '0;
    else if (rd && (off == MTIMER_OFF_TIME_LO))  shadow_hi <= mtime[63:32];
    else if (wr_time_hi)                         shadow_hi <= wdata;
  end

  // Read mux; the hi half of mtime comes from the shadow, not the live count
  always_comb begin
    rd_val = '0;
    case (off)
      MTIMER_OFF_TIME_LO: rd_val = mtime[31:0];
      MTIMER_OFF_TIME_HI: rd_val = shadow_hi;
      MTIMER_OFF_CMP_LO:  rd_val = mtimecmp[31:0];
      MTIMER_OFF_CMP_HI:  rd_val = mtimecmp[63:32];
      default:            rd_val = '0;
    endcase
  end

  // Registered read port; idle cycles hold, stores drop the select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
      sel   <= 1'b0;
    end else if (bus_en) begin
      if (is_st) begin
        sel <= 1'b0;
      end else if (rd) begin
        rdata <= rd_val;
        sel   <= 1'b1;
      end else begin
        rdata <= '0;
        sel   <= 1'b0;
      end
    end
  end

  // Level interrupt from the pre-edge register values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timer_irq <= 1'b0;
    else      timer_irq <= (mtime >= mtimecmp);
  end

endmodule

// File: tb/tb_riscv_mtimer.sv
// Self-checking bench for riscv_mtimer: one PRESCALE=1 and one PRESCALE=4 instance.
module tb_riscv_mtimer;

  localparam logic [2:0] LW = 3'b011, SW = 3'b111, LH = 3'b001, SH = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce1 = 1'b0, ce4 = 1'b0, be1 = 1'b0, be4 = 1'b0;
  logic [2:0]  op = LW;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata1, rdata4;
  logic        sel1, sel4, irq1, irq4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_mtimer #(.BASE_ADDR(32'h0000_c000), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .count_en(ce1), .bus_en(be1), .dmem_op(op),
    .addr(addr), .wdata(wdata), .rdata(rdata1), .sel(sel1), .timer_irq(irq1));

  riscv_mtimer #(.BASE_ADDR(32'h0000_c000), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .count_en(ce4), .bus_en(be4), .dmem_op(op),
    .addr(addr), .wdata(wdata), .rdata(rdata4), .sel(sel4), .timer_irq(irq4));

  typedef struct {
    string       name;
    bit          d4;
    logic [31:0] rdata;
    logic        sel;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_sel;
    bit          chk_sel;
  } vec_t;
  vec_t vecs[19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus strobe; returns one time unit after the capturing edge
  task automatic access(input bit d4, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] d);
    op = o; addr = a; wdata = d;
    if (d4) be4 = 1'b1; else be1 = 1'b1;
    @(posedge clk);
    #1;
    be1 = 1'b0; be4 = 1'b0;
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({e.name, "_rdata"}, e.d4 ? rdata4 : rdata1, e.rdata);
    chk({e.name, "_sel"},   e.d4 ? sel4 : sel1,     e.sel);
  endtask

  task automatic load(input bit d4, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] er, input logic es, input string nm);
    exp_t e;
    e.name = nm; e.d4 = d4; e.rdata = er; e.sel = es;
    sb.push_back(e);
    access(d4, o, a, 32'h0);
    pop_cmp();
  endtask

  initial begin
    vecs[0]  = '{SW, 32'h0000_c000, 32'h1234_5678, 32'h0,          1'b0, 1'b1};
    vecs[1]  = '{SW, 32'h0000_c004, 32'hA5A5_0001, 32'h0,          1'b0, 1'b1};
    vecs[2]  = '{LW, 32'h0000_c000, 32'h0,         32'h1234_5678,  1'b1, 1'b0};
    vecs[3]  = '{LW, 32'h0000_c004, 32'h0,         32'hA5A5_0001,  1'b1, 1'b0};
    vecs[4]  = '{SW, 32'h0000_c008, 32'hDEAD_BEEF, 32'h0,          1'b0, 1'b1};
    vecs[5]  = '{SW, 32'h0000_c00c, 32'h0BAD_F00D, 32'h0,          1'b0, 1'b1};
    vecs[6]  = '{LW, 32'h0000_c008, 32'h0,         32'hDEAD_BEEF,  1'b1, 1'b0};
    vecs[7]  = '{LW, 32'h0000_c00c, 32'h0,         32'h0BAD_F00D,  1'b1, 1'b0};
    vecs[8]  = '{LW, 32'h0000_c010, 32'h0,         32'h0,          1'b0, 1'b0};
    vecs[9]  = '{LH, 32'h0000_c000, 32'h0,         32'h0,          1'b0, 1'b0};
    vecs[10] = '{LW, 32'h0000_c002, 32'h0,         32'h0,          1'b0, 1'b0};
    vecs[11] = '{SW, 32'h0000_c004, 32'h0000_0007, 32'h0,          1'b0, 1'b1};
    vecs[12] = '{LW, 32'h0000_c004, 32'h0,         32'h0000_0007,  1'b1, 1'b0};
    vecs[13] = '{SW, 32'h0000_c010, 32'hFFFF_FFFF, 32'h0,          1'b0, 1'b0};
    vecs[14] = '{SH, 32'h0000_c000, 32'hFFFF_FFFF, 32'h0,          1'b0, 1'b0};
    vecs[15] = '{SW, 32'h0000_d000, 32'hFFFF_FFFF, 32'h0,          1'b0, 1'b0};
    vecs[16] = '{LW, 32'h0000_c000, 32'h0,         32'h1234_5678,  1'b1, 1'b0};
    vecs[17] = '{LW, 32'h0000_c004, 32'h0,         32'h0000_0007,  1'b1, 1'b0};
    vecs[18] = '{LW, 32'h8000_c000, 32'h0,         32'h0,          1'b0, 1'b0};

    // Reset state
    tick_n(2);
    chk("reset_rdata", rdata1, 32'h0);
    chk("reset_sel",   sel1,   1'b0);
    chk("reset_irq",   irq1,   1'b0);

    // Ten counting cycles after release, then freeze and read
    rst = 1'b1; ce1 = 1'b1;
    tick_n(10);
    ce1 = 1'b0;
    load(0, LW, 32'h0000_c000, 32'd10, 1'b1, "count10_lo");
    chk("count10_irq", irq1, 1'b0);

    // Register map / decode table (count frozen)
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].op[DMEM_OP_STORE_BIT_TB()]) begin
        access(0, vecs[i].op, vecs[i].addr, vecs[i].wdata);
        if (vecs[i].chk_sel) chk($sformatf("vec%0d_store_sel", i), sel1, vecs[i].exp_sel);
      end else begin
        load(0, vecs[i].op, vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_sel,
             $sformatf("vec%0d", i));
      end
    end

    // Compare at 5: irq follows mtime reaching 5 by one cycle
    access(0, SW, 32'h0000_c00c, 32'h0);
    access(0, SW, 32'h0000_c008, 32'd5);
    access(0, SW, 32'h0000_c000, 32'h0);
    access(0, SW, 32'h0000_c004, 32'h0);
    ce1 = 1'b1;
    tick_n(5);
    chk("cmp5_irq_at_mtime5", irq1, 1'b0);
    tick_n(1);
    chk("cmp5_irq_rise", irq1, 1'b1);
    ce1 = 1'b0;
    access(0, SW, 32'h0000_c008, 32'd100);
    chk("cmp100_irq_store_edge", irq1, 1'b1);
    tick_n(1);
    chk("cmp100_irq_fall", irq1, 1'b0);

    // Carry into the upper half and the coherent read pair
    access(0, SW, 32'h0000_c004, 32'h0);
    access(0, SW, 32'h0000_c000, 32'hFFFF_FFFF);
    ce1 = 1'b1;
    tick_n(1);
    ce1 = 1'b0;
    load(0, LW, 32'h0000_c000, 32'h0000_0000, 1'b1, "carry_lo");
    load(0, LW, 32'h0000_c004, 32'h0000_0001, 1'b1, "carry_hi");

    // 64-bit wrap against mtimecmp = 10
    access(0, SW, 32'h0000_c00c, 32'hFFFF_FFFF);
    access(0, SW, 32'h0000_c008, 32'd10);
    access(0, SW, 32'h0000_c00c, 32'h0);
    access(0, SW, 32'h0000_c000, 32'hFFFF_FFFF);
    access(0, SW, 32'h0000_c004, 32'hFFFF_FFFF);
    tick_n(1);
    chk("wrap_irq_before", irq1, 1'b1);
    ce1 = 1'b1;
    tick_n(1);
    ce1 = 1'b0;
    chk("wrap_irq_tick_edge", irq1, 1'b1);
    tick_n(1);
    chk("wrap_irq_after", irq1, 1'b0);
    load(0, LW, 32'h0000_c000, 32'h0, 1'b1, "wrap_lo");
    load(0, LW, 32'h0000_c004, 32'h0, 1'b1, "wrap_hi");

    // PRESCALE=4: 8 enabled of 12 cycles gives 2 ticks
    access(1, SW, 32'h0000_c000, 32'h0);
    access(1, SW, 32'h0000_c004, 32'h0);
    ce4 = 1'b1; tick_n(4);
    ce4 = 1'b0; tick_n(4);
    ce4 = 1'b1; tick_n(4);
    ce4 = 1'b0;
    load(1, LW, 32'h0000_c000, 32'd2, 1'b1, "p4_twelve");
    // Store lands on the tick cycle: written value wins, period restarts
    ce4 = 1'b1; tick_n(3);
    access(1, SW, 32'h0000_c000, 32'h0000_0100);
    ce4 = 1'b0;
    load(1, LW, 32'h0000_c000, 32'h0000_0100, 1'b1, "p4_store_tick");
    ce4 = 1'b1; tick_n(3); ce4 = 1'b0;
    load(1, LW, 32'h0000_c000, 32'h0000_0100, 1'b1, "p4_restart_3");
    ce4 = 1'b1; tick_n(1); ce4 = 1'b0;
    load(1, LW, 32'h0000_c000, 32'h0000_0101, 1'b1, "p4_restart_4");

    // Asynchronous reset pulse mid-count
    load(0, LW, 32'h0000_c008, 32'd10, 1'b1, "pre_rst_cmp");
    ce1 = 1'b1; ce4 = 1'b1;
    tick_n(3);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_rdata", rdata1, 32'h0);
    chk("rst_async_sel",   sel1,   1'b0);
    chk("rst_async_sel4",  sel4,   1'b0);
    chk("rst_async_irq",   irq1,   1'b0);
    ce1 = 1'b0; ce4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    load(0, LW, 32'h0000_c000, 32'h0,         1'b1, "rst_mtime_lo");
    load(0, LW, 32'h0000_c004, 32'h0,         1'b1, "rst_mtime_hi");
    load(0, LW, 32'h0000_c008, 32'hFFFF_FFFF, 1'b1, "rst_cmp_lo");
    load(0, LW, 32'h0000_c00c, 32'hFFFF_FFFF, 1'b1, "rst_cmp_hi");
    chk("rst_irq_after", irq1, 1'b0);
    // First tick after release needs PRESCALE enabled cycles
    ce4 = 1'b1; tick_n(3); ce4 = 1'b0;
    load(1, LW, 32'h0000_c000, 32'h0, 1'b1, "rst_p4_3");
    ce4 = 1'b1; tick_n(1); ce4 = 1'b0;
    load(1, LW, 32'h0000_c000, 32'h1, 1'b1, "rst_p4_4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic int DMEM_OP_STORE_BIT_TB();
    return 2;
  endfunction

  // Hard stop in case anything above stalls
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
